cache_refill_broadcast_arbiter: RTL and testbench

Shared refill stage that sits directly downstream of N directly-mapped broadcast caches (one per basic block / engine), between their miss ports and the block-wide backing memory. It arbitrates the miss requests round-robin, fetches one whole cache block from memory, and broadcasts block address plus data to every cache at once. Any cache may install the block, whether or not it requested it. Memory is read-only in this context, so no coherence logic is needed.

---
 rtl/cache_refill_broadcast_arbiter_pkg.sv | 21 ++
 rtl/cache_refill_broadcast_arbiter_if.sv | 34 +++
 rtl/cache_refill_broadcast_arbiter_rr_arbiter.sv | 35 +++
 rtl/cache_refill_broadcast_arbiter.sv | 105 ++++++++++
 tb/tb_cache_refill_broadcast_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_refill_broadcast_arbiter_pkg.sv
// Shared types and sizing helpers for the cache refill broadcast arbiter.
package cache_refill_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_GRANT
    } refill_state_t;

    localparam int DEF_N_PORTS          = 4;
    localparam int DEF_DWIDTH           = 4;
    localparam int DEF_BLOCK_WIDTH_BITS = 4;
    localparam int DEF_OUT_ADDR_WIDTH   = 12;

    // One cache block holds 2**block_bits words of dwidth bits each.
    function automatic int calc_block_w(input int dwidth, input int block_bits);
        return dwidth * (2 ** block_bits);
    endfunction

endpackage

// File: rtl/cache_refill_broadcast_arbiter_if.sv
// Miss-request, broadcast and memory-read bundle of the refill arbiter.
interface cache_refill_broadcast_arbiter_if
    import cache_refill_pkg::*;
#(
    parameter int N_PORTS          = DEF_N_PORTS,
    parameter int DWIDTH           = DEF_DWIDTH,
    parameter int BLOCK_WIDTH_BITS = DEF_BLOCK_WIDTH_BITS,
    parameter int OUT_ADDR_WIDTH   = DEF_OUT_ADDR_WIDTH
);
    localparam int BLOCK_W = calc_block_w(DWIDTH, BLOCK_WIDTH_BITS);

    logic [N_PORTS-1:0]                req_valid;
    logic [N_PORTS*OUT_ADDR_WIDTH-1:0] req_addr;
    logic [N_PORTS-1:0]                req_ready;
    logic                              bcast_valid;
    logic [OUT_ADDR_WIDTH-1:0]         bcast_addr;
    logic [BLOCK_W-1:0]                bcast_data;
    logic                              mem_req_valid;
    logic [OUT_ADDR_WIDTH-1:0]         mem_addr;
    logic                              mem_req_ready;
    logic                              mem_rvalid;
    logic [BLOCK_W-1:0]                mem_rdata;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, bcast_valid, bcast_addr, bcast_data, mem_req_valid, mem_addr
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, bcast_valid, bcast_addr, bcast_data, mem_req_valid, mem_addr
    );

endinterface

// File: rtl/cache_refill_broadcast_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [2*N-1:0] rot_full;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_first;
    logic [2*N-1:0] unrot_full;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign rot_full   = {req, req} >> ptr;
    assign rot        = rot_full[N-1:0];
    assign rot_first  = rot & (~rot + {{(N-1){1'b0}}, 1'b1});
    assign unrot_full = {rot_first, rot_first} << ptr;
    assign grant      = unrot_full[2*N-1:N];
    assign any        = |req;

    generate
        for (genvar gb = 0; gb < IW; gb++) begin : g_idx_bit
            logic [N-1:0] bit_sel;
            for (genvar gi = 0; gi < N; gi++) begin : g_port
                assign bit_sel[gi] = (((gi >> gb) & 1) != 0) ? grant[gi] : 1'b0;
            end
            assign idx[gb] = |bit_sel;
        end
    endgenerate

endmodule

// File: rtl/cache_refill_broadcast_arbiter.sv
// Round-robin refill stage: fetches one block per miss and broadcasts it to all caches.
module cache_refill_broadcast_arbiter
    import cache_refill_pkg::*;
#(
    parameter int N_PORTS          = DEF_N_PORTS,
    parameter int DWIDTH           = DEF_DWIDTH,
    parameter int BLOCK_WIDTH_BITS = DEF_BLOCK_WIDTH_BITS,
    parameter int OUT_ADDR_WIDTH   = DEF_OUT_ADDR_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst,
    cache_refill_broadcast_arbiter_if.slave    bus
);
    localparam int BLOCK_W = calc_block_w(DWIDTH, BLOCK_WIDTH_BITS);
    localparam int IW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    refill_state_t             state_q, state_d;
    logic [IW-1:0]             winner_q, winner_d;
    logic [N_PORTS-1:0]        winner_oh_q, winner_oh_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [OUT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BLOCK_W-1:0]        data_q, data_d;

    logic [N_PORTS-1:0]        arb_grant;
    logic [IW-1:0]             arb_idx;
    logic                      arb_any;
    logic [OUT_ADDR_WIDTH-1:0] port_addr [N_PORTS];

    generate
        for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port_addr
            assign port_addr[gi] = bus.req_addr[gi*OUT_ADDR_WIDTH +: OUT_ADDR_WIDTH];
        end
    endgenerate

    rr_arbiter #(.N(N_PORTS)) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        winner_oh_d = winner_oh_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    winner_d    = arb_idx;
                    winner_oh_d = arb_grant;
                    addr_d      = port_addr[arb_idx];
                    state_d     = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                // Broadcast data changes only here, so it stays valid through GRANT+1.
                if (bus.mem_rvalid) begin
                    data_d  = bus.mem_rdata;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                rr_ptr_d = (winner_q == IW'(N_PORTS - 1)) ? '0 : winner_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            winner_q    <= '0;
            winner_oh_q <= '0;
            rr_ptr_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            winner_oh_q <= winner_oh_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // The acknowledge is not gated by the live req_valid: a withdrawn winner still sees its pulse.
    assign bus.req_ready     = (state_q == S_GRANT)   ? winner_oh_q : '0;
    assign bus.bcast_valid   = (state_q == S_GRANT);
    assign bus.bcast_addr    = (state_q == S_GRANT)   ? addr_q : '0;
    assign bus.bcast_data    = data_q;
    assign bus.mem_req_valid = (state_q == S_MEM_REQ);
    assign bus.mem_addr      = (state_q == S_MEM_REQ) ? addr_q : '0;

endmodule

// File: tb/tb_cache_refill_broadcast_arbiter.sv
// Directed scoreboard bench for the refill broadcast arbiter with a small memory model.
module tb_cache_refill_broadcast_arbiter;
    import cache_refill_pkg::*;

    localparam int NP = 4;
    localparam int AW = 12;
    localparam int BW = 64;

    typedef struct {
        logic [NP-1:0] ready;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   ready_delay = 0;
    int   rd_lat = 1;
    exp_t sb[$];

    cache_refill_broadcast_arbiter_if #(
        .N_PORTS(NP), .DWIDTH(4), .BLOCK_WIDTH_BITS(4), .OUT_ADDR_WIDTH(AW)
    ) bus ();

    cache_refill_broadcast_arbiter #(
        .N_PORTS(NP), .DWIDTH(4), .BLOCK_WIDTH_BITS(4), .OUT_ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [BW-1:0] mem_word(input logic [AW-1:0] a);
        logic [AW-1:0] s;
        s = a + 12'h3C3;
        return {a, ~a, a ^ 12'h5A5, s, {4'hC, a} ^ 16'hBEEF};
    endfunction

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a);
        bus.req_addr[p*AW +: AW] = a;
    endtask

    task automatic push_exp(input int p, input logic [AW-1:0] a);
        exp_t e;
        e.ready = NP'(1) << p;
        e.addr  = a;
        e.data  = mem_word(a);
        sb.push_back(e);
    endtask

    task automatic wait_bcast(input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.bcast_valid) found = 1;
        end
        if (!found) check("bcast_timeout", 64'(bus.bcast_valid), 64'd1);
    endtask

    task automatic wait_memreq(input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.mem_req_valid) found = 1;
        end
        if (!found) check("memreq_timeout", 64'(bus.mem_req_valid), 64'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"},   64'(bus.req_ready),     64'd0);
        check({tag, "_bcast_valid"}, 64'(bus.bcast_valid),   64'd0);
        check({tag, "_bcast_addr"},  64'(bus.bcast_addr),    64'd0);
        check({tag, "_mem_valid"},   64'(bus.mem_req_valid), 64'd0);
        check({tag, "_mem_addr"},    64'(bus.mem_addr),      64'd0);
        check({tag, "_bcast_data"},  bus.bcast_data,         64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    // Memory model: programmable accept stall and read latency; junk rvalid when nothing is outstanding.
    initial begin
        int stall = 0;
        int cnt = 0;
        bit pend = 0;
        bit junk = 0;
        logic [AW-1:0] paddr = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.mem_rvalid    = 1'b0;
            junk = ~junk;
            if (rst) begin
                pend = 0; stall = 0; cnt = 0;
            end else if (pend) begin
                cnt++;
                if (cnt >= rd_lat) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = mem_word(paddr);
                    pend = 0;
                end
            end else if (bus.mem_req_valid && stall >= ready_delay) begin
                bus.mem_req_ready = 1'b1;
                pend = 1; cnt = 0; stall = 0;
                paddr = bus.mem_addr;
            end else begin
                if (bus.mem_req_valid) stall++;
                bus.mem_rvalid = junk;
                bus.mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end
    end

    // Monitor: pops the scoreboard on each broadcast and checks data hold at GRANT+1.
    initial begin
        bit chk = 0;
        bit prev_mrv = 0;
        logic [BW-1:0] hold = '0;
        logic [AW-1:0] prev_maddr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk = 0; prev_mrv = 0;
            end else begin
                if (bus.bcast_valid) begin
                    check("bcast_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("bcast_addr", 64'(bus.bcast_addr), 64'(e.addr));
                        check("req_ready",  64'(bus.req_ready),  64'(e.ready));
                        check("bcast_data", bus.bcast_data,      e.data);
                        $display("grant cyc=%0d ready=%b addr=%h data=%h", cyc, bus.req_ready, bus.bcast_addr, bus.bcast_data);
                    end
                    chk = 1;
                    hold = bus.bcast_data;
                end else if (chk) begin
                    check("data_hold_grant1",  bus.bcast_data,       hold);
                    check("ready_single_pulse", 64'(bus.req_ready),  64'd0);
                    chk = 0;
                end
                if (bus.mem_req_valid && prev_mrv)
                    check("mem_addr_stable", 64'(bus.mem_addr), 64'(prev_maddr));
                prev_mrv   = bus.mem_req_valid;
                prev_maddr = bus.mem_addr;
            end
        end
    end

    initial begin
        int c0;
        int last;
        bus.req_valid = '0;
        bus.req_addr  = '0;

        // Single request, minimum latency.
        do_reset();
        @(negedge clk);
        set_port(2, 12'h0A5);
        bus.req_valid = 4'b0100;
        push_exp(2, 12'h0A5);
        @(negedge clk);
        check("c1_mem_valid", 64'(bus.mem_req_valid), 64'd1);
        check("c1_mem_addr",  64'(bus.mem_addr),      64'h0A5);
        check("c1_no_bcast",  64'(bus.bcast_valid),   64'd0);
        @(negedge clk);
        check("c2_mem_valid", 64'(bus.mem_req_valid), 64'd0);
        check("c2_no_bcast",  64'(bus.bcast_valid),   64'd0);
        @(negedge clk);
        check("c3_bcast_valid", 64'(bus.bcast_valid), 64'd1);
        bus.req_valid = '0;
        drain("single");

        // Fairness with all ports requesting continuously.
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, AW'(12'h100 + p));
        bus.req_valid = 4'b1111;
        for (int p = 0; p < NP; p++) push_exp(p, AW'(12'h100 + p));
        push_exp(0, 12'h100);
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_bcast(20);
            if (g > 0) check("fair_gap", 64'(cyc - last), 64'd4);
            last = cyc;
            if (g == 4) bus.req_valid = '0;
        end
        drain("fair");

        // Same-address collision between ports 0 and 1.
        do_reset();
        set_port(0, 12'h010);
        set_port(1, 12'h010);
        bus.req_valid = 4'b0011;
        push_exp(0, 12'h010);
        push_exp(1, 12'h010);
        wait_bcast(20);
        bus.req_valid = 4'b0010;
        wait_bcast(20);
        bus.req_valid = '0;
        drain("collide");

        // Memory back-pressure: 5 stalled cycles, 3-cycle read.
        do_reset();
        ready_delay = 5;
        rd_lat = 3;
        @(negedge clk);
        c0 = cyc;
        set_port(1, 12'h3C7);
        bus.req_valid = 4'b0010;
        push_exp(1, 12'h3C7);
        wait_bcast(40);
        check("bp_latency", 64'(cyc - c0), 64'd10);
        bus.req_valid = '0;
        ready_delay = 0;
        drain("backpressure");

        // Winner withdraws during the memory wait.
        do_reset();
        rd_lat = 3;
        set_port(3, 12'h2F0);
        bus.req_valid = 4'b1000;
        push_exp(3, 12'h2F0);
        wait_memreq(20);
        @(negedge clk);
        bus.req_valid = '0;
        wait_bcast(20);
        rd_lat = 1;
        for (int p = 0; p < NP; p++) set_port(p, AW'(12'h200 + p));
        bus.req_valid = 4'b1111;
        push_exp(0, 12'h200);
        wait_bcast(20);
        bus.req_valid = '0;
        drain("withdraw");

        // Reset while waiting on memory; bcast_data holds the previous capture beforehand.
        rd_lat = 4;
        set_port(1, 12'h055);
        bus.req_valid = 4'b0010;
        wait_memreq(20);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        check_outputs_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        rd_lat = 1;
        set_port(0, 12'h0F0);
        set_port(3, 12'h777);
        bus.req_valid = 4'b1001;
        push_exp(0, 12'h0F0);
        push_exp(3, 12'h777);
        wait_bcast(20);
        bus.req_valid = 4'b1000;
        wait_bcast(20);
        bus.req_valid = '0;
        drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
